alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Shares the single 8-bit ALU between two requesters (req0, req1) using round-robin arbitration and a valid/ready handshake.
- Sequences each accepted operation through execute and response phases.
- Keeps a private carry flag per requester, so interleaved add/subtract-with-carry chains from the two requesters do not corrupt each other.
- Sits between the datapath's operand sources and the ALU; it drives every ALU control input and captures the ALU's R/zero/carry_out.

## Interface
- WIDTH, 8, operand/result width; only 8 is supported, matching the ALU.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: operation from requester i accepted this cycle; one-hot or zero.
- reqN_a, reqN_b  in  8 each (N=0,1)  operands.
- reqN_acode  in  3  arithmetic/logic code.
- reqN_scode  in  2  shift code.
- reqN_shift  in  1  1 selects the shift/rotate path.
- alu_a, alu_b  out  8  ALU operands.
- alu_carry_in  out  1  ALU carry input.
- alu_is_shift  out  1  ALU shift select.
- alu_scode  out  2  ALU shift code.
- alu_acode  out  3  ALU arithmetic/logic code.
- alu_r  in  8  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_carry_out  in  1  ALU carry output.
- rsp_valid  out  2  one-cycle pulse to the owning requester.
- rsp_r  out  8  result.
- rsp_zero  out  1  result is zero.
- rsp_carry  out  1  owner's carry flag after the operation.
- rsp_err  out  1  illegal operation code.
- busy  out  1  high in EXEC.

## Operation
- **States:** IDLE, EXEC, RESP. All three are binary-encoded.
- **Accept:**
  - Allowed in IDLE or RESP when any req_valid is high.
  - The winner's req_ready pulses high for that cycle.
  - Operands and codes are latched into op registers, and the owner is recorded.
  - The next state is EXEC.
- **Arbitration:**
  - If only one requester is valid, it wins.
  - If both are valid, the one not granted last wins.
  - last_grant resets to 1, so req0 wins the first tie.
- **Handshake rules:**
  - Requester fields must be held stable while valid=1 and ready=0.
  - A requester must not drop valid before ready.
  - The arbiter never grants a requester whose valid=0.
- **EXEC:**
  - alu_* are driven from the op registers.
  - alu_carry_in equals the owner's carry flag.
  - At the end of EXEC, alu_r, alu_zero and alu_carry_out are captured into the response registers.
  - The next state is RESP.
- **RESP:**
  - rsp_valid[owner] is 1 for exactly one cycle.
  - rsp_r, rsp_zero, rsp_carry and rsp_err hold the captured values until the next capture.
  - The next state is EXEC if a new request was accepted this cycle, otherwise IDLE.
- **Carry flags** (carry0, carry1; reset 0):
  - Non-shift acode 000–011: the owner's flag is loaded with alu_carry_out at EXEC end.
  - acode 100/110 and all shifts leave the flag unchanged.
  - The other requester's flag is never touched.
- **Shift operand:** when the shift path is selected, alu_b = {5'b0, b[2:0]}. This keeps the amount within 0–7, as the ALU rotate indexing requires.
- **Illegal operations** (non-shift acode 101 or 111):
  - The ALU result is ignored.
  - rsp_r=0, rsp_zero=1, rsp_err=1.
  - The carry flag is unchanged.
  - The operation still consumes EXEC and RESP.
- **Reset:**
  - Asynchronously returns the state to IDLE.
  - Clears the op registers, all alu_* outputs, response registers and both carry flags; last_grant=1.
  - req_ready=0, rsp_valid=0, busy=0.
  - An in-flight operation is dropped and produces no response.

## Timing
- **Latency:**
  - Request accepted in cycle t (valid&ready).
  - EXEC in cycle t+1.
  - rsp_valid in cycle t+2.
- **Throughput:** one operation per 2 cycles, because accept overlaps RESP.
- **Outputs:**
  - req_ready is combinational from state and req_valid.
  - All other outputs are registered.
- **Back-to-back on one requester:** the second operation's alu_carry_in sees the flag updated by the first operation.
- **Simultaneous events:**
  - A new accept in RESP does not disturb the response being presented.
  - The response registers change only at EXEC end.
- **Reset deassertion:** the first accept is possible in the first clock cycle after rst_n rises.

## Test plan
- **Reset:**
  - Stimulus: assert rst_n=0 mid-EXEC.
  - Required: all outputs 0 immediately; no rsp_valid after release; carry0=carry1=0.
- **Single add:**
  - Stimulus: req0 a=8'h F0, b=8'h 20, acode=000.
  - Required: ready at t; rsp_valid[0] at t+2; rsp_r=8'h10, rsp_carry=1, rsp_zero=0.
- **Round-robin and carry isolation:**
  - Stimulus: both requesters valid continuously. req0 does ADC (001) 8'h FF+8'h 01; req1 does ADC 8'h 01+8'h 01.
  - Required: grants alternate 0,1,0,1. req0 results 00(c=1), then 01(c=1). req1 results 02(c=0) each time.
- **Shift operand masking:**
  - Stimulus: req1 shift=1, scode=00, a=8'h 01, b=8'h 0B.
  - Required: alu_b=8'h 03; rsp_r=8'h 08; carry1 unchanged.
- **Illegal code:**
  - Stimulus: req0 acode=101 with carry0=1.
  - Required: rsp_r=0, rsp_zero=1, rsp_err=1; carry0 stays 1.
- **Back-pressure and throughput:**
  - Stimulus: req1 held valid while req0 owns the ALU.
  - Required: req1 fields sampled only at its ready. Steady-state rsp_valid every 2 cycles with no lost or duplicated responses.

Source files
------------

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : requester, ALU and response bundle of the shared-ALU arbiter
// Revision 1.0
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_acode;
  logic [1:0]       req0_scode;
  logic             req0_shift;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_acode;
  logic [1:0]       req1_scode;
  logic             req1_shift;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_carry_in;
  logic             alu_is_shift;
  logic [1:0]       alu_scode;
  logic [2:0]       alu_acode;
  logic [WIDTH-1:0] alu_r;
  logic             alu_zero;
  logic             alu_carry_out;

  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_r;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req_valid, req0_a, req0_b, req0_acode, req0_scode, req0_shift,
           req1_a, req1_b, req1_acode, req1_scode, req1_shift,
           alu_r, alu_zero, alu_carry_out,
    output req_ready, alu_a, alu_b, alu_carry_in, alu_is_shift, alu_scode, alu_acode,
           rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_err, busy
  );

  modport master (
    output req_valid, req0_a, req0_b, req0_acode, req0_scode, req0_shift,
           req1_a, req1_b, req1_acode, req1_scode, req1_shift,
           alu_r, alu_zero, alu_carry_out,
    input  req_ready, alu_a, alu_b, alu_carry_in, alu_is_shift, alu_scode, alu_acode,
           rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin valid/ready front end for one shared 8-bit ALU
// Revision 1.0
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  wire          clk,
  input  wire          rst_n,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [1:0]       r_carry;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_cin;
  logic             r_op_shift;
  logic [1:0]       r_op_scode;
  logic [2:0]       r_op_acode;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_r;
  logic             r_rsp_zero;
  logic             r_rsp_carry;
  logic             r_rsp_err;
  logic             r_busy;

  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_win;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_sel_b_eff;
  logic [2:0]       w_sel_acode;
  logic [1:0]       w_sel_scode;
  logic             w_sel_shift;
  logic             w_illegal;
  logic             w_carry_upd;
  logic             w_owner_carry;

  // Ties go to the requester that was not granted last.
  always_comb begin
    w_grant = 2'b00;
    if (rst_n && (r_state == S_IDLE || r_state == S_RESP)) begin
      case (bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_accept      = |w_grant;
  assign w_win         = w_grant[1];
  assign bus.req_ready = w_grant;

  assign w_sel_a     = w_win ? bus.req1_a     : bus.req0_a;
  assign w_sel_b     = w_win ? bus.req1_b     : bus.req0_b;
  assign w_sel_acode = w_win ? bus.req1_acode : bus.req0_acode;
  assign w_sel_scode = w_win ? bus.req1_scode : bus.req0_scode;
  assign w_sel_shift = w_win ? bus.req1_shift : bus.req0_shift;
  // The ALU rotator only indexes 0..7, so the shift amount is clipped on entry.
  assign w_sel_b_eff = w_sel_shift ? {{(WIDTH-3){1'b0}}, w_sel_b[2:0]} : w_sel_b;

  assign w_illegal     = !r_op_shift && r_op_acode[2] && r_op_acode[0];
  assign w_carry_upd   = !r_op_shift && !r_op_acode[2];
  assign w_owner_carry = r_carry[r_owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_carry      <= 2'b00;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_cin     <= 1'b0;
      r_op_shift   <= 1'b0;
      r_op_scode   <= 2'b00;
      r_op_acode   <= 3'b000;
      r_rsp_valid  <= 2'b00;
      r_rsp_r      <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_carry  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rsp_valid <= 2'b00;
      r_busy      <= 1'b0;

      case (r_state)
        S_IDLE, S_RESP: r_state <= w_accept ? S_EXEC : S_IDLE;
        S_EXEC:         r_state <= S_RESP;
        default:        r_state <= S_IDLE;
      endcase

      if (w_accept) begin
        r_op_a       <= w_sel_a;
        r_op_b       <= w_sel_b_eff;
        r_op_cin     <= r_carry[w_win];
        r_op_shift   <= w_sel_shift;
        r_op_scode   <= w_sel_scode;
        r_op_acode   <= w_sel_acode;
        r_owner      <= w_win;
        r_last_grant <= w_win;
        r_busy       <= 1'b1;
      end

      if (r_state == S_EXEC) begin
        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
        if (w_illegal) begin
          r_rsp_r     <= '0;
          r_rsp_zero  <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_carry <= w_owner_carry;
        end else begin
          r_rsp_r     <= bus.alu_r;
          r_rsp_zero  <= bus.alu_zero;
          r_rsp_err   <= 1'b0;
          r_rsp_carry <= w_carry_upd ? bus.alu_carry_out : w_owner_carry;
        end
        if (w_carry_upd) begin
          r_carry[r_owner] <= bus.alu_carry_out;
        end
      end
    end
  end

  assign bus.alu_a        = r_op_a;
  assign bus.alu_b        = r_op_b;
  assign bus.alu_carry_in = r_op_cin;
  assign bus.alu_is_shift = r_op_shift;
  assign bus.alu_scode    = r_op_scode;
  assign bus.alu_acode    = r_op_acode;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_r        = r_rsp_r;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.rsp_carry    = r_rsp_carry;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : vector table, reset/round-robin sequences and random traffic
// Revision 1.0
// ============================================================================
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(8)) ifc ();
  alu_arbiter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Reference ALU: bit 8 is carry (add) or borrow (subtract).
  function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sh,
                                         input logic [1:0] sc, input logic [2:0] ac);
    logic [15:0] t;
    t = {a, a};
    ref_alu = 9'h000;
    if (sh) begin
      case (sc)
        2'b00:   ref_alu = {1'b0, a << b};
        2'b01:   ref_alu = {1'b0, a >> b};
        2'b10:   begin t = t << b[2:0]; ref_alu = {1'b0, t[15:8]}; end
        default: begin t = t >> b[2:0]; ref_alu = {1'b0, t[7:0]}; end
      endcase
    end else begin
      case (ac)
        3'b000:  ref_alu = {1'b0, a} + {1'b0, b};
        3'b001:  ref_alu = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        3'b010:  ref_alu = {1'b0, a} - {1'b0, b};
        3'b011:  ref_alu = {1'b0, a} - {1'b0, b} - {8'h00, cin};
        3'b100:  ref_alu = {1'b0, a & b};
        3'b101:  ref_alu = {1'b1, a ^ b};
        3'b110:  ref_alu = {1'b0, a | b};
        default: ref_alu = {1'b1, ~a};
      endcase
    end
  endfunction

  logic [8:0] env_t;
  assign env_t = ref_alu(ifc.alu_a, ifc.alu_b, ifc.alu_carry_in, ifc.alu_is_shift,
                         ifc.alu_scode, ifc.alu_acode);
  assign ifc.alu_r         = env_t[7:0];
  assign ifc.alu_carry_out = env_t[8];
  assign ifc.alu_zero      = (env_t[7:0] == 8'h00);

  typedef struct {
    int         cyc;
    logic [1:0] own;
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       e;
  } rsp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sh;
    logic [1:0] sc;
    logic [2:0] ac;
  } exec_t;

  typedef struct {
    int         own;
    logic [7:0] r;
    logic       c;
  } log_t;

  typedef struct {
    int         req;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] ac;
    logic [1:0] sc;
    logic       sh;
    logic [7:0] er;
    logic       ez;
    logic       ec;
    logic       ee;
  } vec_t;

  int    n_pass, n_total, cyc;
  int    m_next_ok, m_exec_cyc;
  logic  m_last;
  logic  m_carry [2];
  logic [1:0] m_acc;
  rsp_t  rq[$];
  rsp_t  m_hold;
  exec_t m_x;
  int    gnt_log[$];
  log_t  rsp_log[$];
  int    l_own;
  logic [7:0] l_r;
  logic  l_z, l_c, l_e;
  vec_t  vecs [12];
  int    n0, n1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_next_ok  = 0;
    m_exec_cyc = -10;
    m_last     = 1'b1;
    m_carry[0] = 1'b0;
    m_carry[1] = 1'b0;
    m_acc      = 2'b00;
    rq.delete();
    m_hold     = '{cyc: 0, own: 2'b00, r: 8'h00, z: 1'b0, c: 1'b0, e: 1'b0};
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] ac, input logic [1:0] sc, input logic sh);
    if (i == 0) begin
      ifc.req0_a = a; ifc.req0_b = b; ifc.req0_acode = ac; ifc.req0_scode = sc; ifc.req0_shift = sh;
    end else begin
      ifc.req1_a = a; ifc.req1_b = b; ifc.req1_acode = ac; ifc.req1_scode = sc; ifc.req1_shift = sh;
    end
  endtask

  // Transaction-level model: an accept reserves the ALU for two cycles and
  // schedules its response two cycles later.
  task automatic monitor();
    logic [1:0] exp_rdy, exp_v;
    logic       w, sh, ill;
    logic [7:0] a, b, bm;
    logic [2:0] ac;
    logic [1:0] sc;
    logic [8:0] t;
    rsp_t       e;
    exp_rdy = 2'b00;
    w = 1'b0;
    if (cyc >= m_next_ok && ifc.req_valid != 2'b00) begin
      if (ifc.req_valid == 2'b11) w = m_last ? 1'b0 : 1'b1;
      else w = ifc.req_valid[1];
      exp_rdy = w ? 2'b10 : 2'b01;
    end
    chk("req_ready", ifc.req_ready, exp_rdy);
    chk("busy", ifc.busy, cyc == m_exec_cyc);
    if (cyc == m_exec_cyc) begin
      chk("alu_a", ifc.alu_a, m_x.a);
      chk("alu_b", ifc.alu_b, m_x.b);
      chk("alu_carry_in", ifc.alu_carry_in, m_x.cin);
      chk("alu_ctl", {ifc.alu_is_shift, ifc.alu_scode, ifc.alu_acode}, {m_x.sh, m_x.sc, m_x.ac});
    end
    exp_v = 2'b00;
    if (rq.size() != 0 && rq[0].cyc == cyc) begin
      m_hold = rq.pop_front();
      exp_v  = m_hold.own;
    end
    chk("rsp_valid", ifc.rsp_valid, exp_v);
    chk("rsp_fields", {ifc.rsp_r, ifc.rsp_zero, ifc.rsp_carry, ifc.rsp_err},
        {m_hold.r, m_hold.z, m_hold.c, m_hold.e});
    if (ifc.rsp_valid != 2'b00) begin
      l_own = ifc.rsp_valid[1] ? 1 : 0;
      l_r = ifc.rsp_r; l_z = ifc.rsp_zero; l_c = ifc.rsp_carry; l_e = ifc.rsp_err;
      rsp_log.push_back('{own: l_own, r: ifc.rsp_r, c: ifc.rsp_carry});
    end
    if (ifc.req_ready != 2'b00) gnt_log.push_back(ifc.req_ready[1] ? 1 : 0);
    m_acc = ifc.req_valid & ifc.req_ready;
    if (exp_rdy != 2'b00) begin
      a  = w ? ifc.req1_a : ifc.req0_a;
      b  = w ? ifc.req1_b : ifc.req0_b;
      ac = w ? ifc.req1_acode : ifc.req0_acode;
      sc = w ? ifc.req1_scode : ifc.req0_scode;
      sh = w ? ifc.req1_shift : ifc.req0_shift;
      bm = sh ? (b % 8) : b;
      m_x = '{a: a, b: bm, cin: m_carry[w], sh: sh, sc: sc, ac: ac};
      ill = !sh && (ac == 3'b101 || ac == 3'b111);
      e.cyc = cyc + 2;
      e.own = exp_rdy;
      if (ill) begin
        e.r = 8'h00; e.z = 1'b1; e.e = 1'b1; e.c = m_carry[w];
      end else begin
        t = ref_alu(a, bm, m_carry[w], sh, sc, ac);
        if (!sh && ac < 3'd4) m_carry[w] = t[8];
        e.r = t[7:0]; e.z = (t[7:0] == 8'h00); e.e = 1'b0; e.c = m_carry[w];
      end
      rq.push_back(e);
      m_last     = w;
      m_next_ok  = cyc + 2;
      m_exec_cyc = cyc + 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    vecs[0]  = '{0, 8'hF0, 8'h20, 3'b000, 2'b00, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{0, 8'h55, 8'h0F, 3'b101, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1, 8'h01, 8'h0B, 3'b000, 2'b00, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'h10, 8'h05, 3'b001, 2'b00, 1'b0, 8'h16, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1, 8'h05, 8'h07, 3'b010, 2'b00, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1, 8'h05, 8'h05, 3'b011, 2'b00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{0, 8'hF0, 8'h0F, 3'b100, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1, 8'h81, 8'h01, 3'b000, 2'b11, 1'b1, 8'hC0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{0, 8'h00, 8'h00, 3'b110, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1, 8'h3C, 8'h11, 3'b111, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{0, 8'h80, 8'h0F, 3'b000, 2'b01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1, 8'h81, 8'h01, 3'b000, 2'b10, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0};

    n_pass = 0; n_total = 0; cyc = 0;
    rst_n = 1'b0;
    ifc.req_valid = 2'b11;
    set_req(0, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
    set_req(1, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
    model_reset();
    repeat (3) begin @(posedge clk); cyc++; end
    #1;
    chk("rst_ready", ifc.req_ready, 2'b00);
    chk("rst_ctl", {ifc.rsp_valid, ifc.busy, ifc.alu_a, ifc.alu_b, ifc.alu_carry_in,
                    ifc.alu_is_shift, ifc.alu_scode, ifc.alu_acode}, 0);
    chk("rst_rsp", {ifc.rsp_r, ifc.rsp_zero, ifc.rsp_carry, ifc.rsp_err}, 0);
    ifc.req_valid = 2'b00;
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      l_own = -1;
      set_req(vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].ac, vecs[v].sc, vecs[v].sh);
      ifc.req_valid = (vecs[v].req == 1) ? 2'b10 : 2'b01;
      step();
      ifc.req_valid = 2'b00;
      step();
      step();
      chk("vec_owner", l_own, vecs[v].req);
      chk("vec_r", l_r, vecs[v].er);
      chk("vec_zero", l_z, vecs[v].ez);
      chk("vec_carry", l_c, vecs[v].ec);
      chk("vec_err", l_e, vecs[v].ee);
    end

    // Asynchronous reset in the middle of EXEC drops the operation.
    set_req(0, 8'h03, 8'h04, 3'b001, 2'b00, 1'b0);
    ifc.req_valid = 2'b01;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", ifc.req_ready, 2'b00);
    chk("midrst_ctl", {ifc.rsp_valid, ifc.busy, ifc.alu_a, ifc.alu_b, ifc.alu_carry_in,
                       ifc.alu_is_shift, ifc.alu_scode, ifc.alu_acode}, 0);
    chk("midrst_rsp", {ifc.rsp_r, ifc.rsp_zero, ifc.rsp_carry, ifc.rsp_err}, 0);
    repeat (2) begin @(posedge clk); cyc++; end
    #1;

    // Round robin with both requesters chaining ADC from a fresh reset.
    set_req(0, 8'hFF, 8'h01, 3'b001, 2'b00, 1'b0);
    set_req(1, 8'h01, 8'h01, 3'b001, 2'b00, 1'b0);
    ifc.req_valid = 2'b11;
    model_reset();
    gnt_log.delete();
    rsp_log.delete();
    rst_n = 1'b1;
    repeat (9) step();
    ifc.req_valid = 2'b00;
    repeat (3) step();
    for (int i = 0; i < 4; i++)
      chk("rr_grant", (i < gnt_log.size()) ? gnt_log[i] : -1, i % 2);
    n0 = 0; n1 = 0;
    foreach (rsp_log[k]) begin
      if (rsp_log[k].own == 0 && n0 < 2) begin
        chk("rr_r0", rsp_log[k].r, (n0 == 0) ? 8'h00 : 8'h01);
        chk("rr_c0", rsp_log[k].c, 1'b1);
        n0++;
      end else if (rsp_log[k].own == 1 && n1 < 2) begin
        chk("rr_r1", rsp_log[k].r, 8'h02);
        chk("rr_c1", rsp_log[k].c, 1'b0);
        n1++;
      end
    end
    chk("rr_resp_count", n0 + n1, 4);

    // Random legal traffic: fields held while valid is waiting for ready.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(ifc.req_valid[i] && !m_acc[i])) begin
          if ($urandom_range(2) != 0) begin
            ifc.req_valid[i] = 1'b1;
            set_req(i, 8'($urandom), 8'($urandom), 3'($urandom), 2'($urandom),
                    ($urandom_range(3) == 0));
          end else begin
            ifc.req_valid[i] = 1'b0;
          end
        end
      end
      step();
    end
    ifc.req_valid = 2'b00;
    repeat (3) step();
    chk("drain_empty", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
